// File: rtl/debounce_pkg.sv
// Shared types and parameter legality checks for the debounce scheduler.
package debounce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic bit n_ok(input int n);
        return (n >= 2) && (n <= 16);
    endfunction

    function automatic bit hist_ok(input int hist);
        return (hist >= 2) && (hist <= 16);
    endfunction

    function automatic bit div_ok(input int n, input int div);
        return div >= (n + 2);
    endfunction

    function automatic bit params_ok(input int n, input int hist, input int div);
        return n_ok(n) && hist_ok(hist) && div_ok(n, div);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period prescaler: free-running 0..DIV-1 counter with a one-cycle tick on the last count.
module sample_tick_gen #(
    parameter int DIV = 32768
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    assign tick = (div_cnt_q == DW'(DIV - 1));

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// N-channel switch debouncer: one shared shift-history engine scans all channels once per
// sample period and posts level changes through a valid/ready event port.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter int N    = 8,
    parameter int HIST = 10,
    parameter int DIV  = 32768,
    localparam int CW  = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  insig,
    output logic [N-1:0]  stable,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [CW-1:0] ev_chan,
    output logic          ev_level,
    output logic          lost_event,
    output logic          busy
);

    if (!params_ok(N, HIST, DIV)) begin : g_illegal_params
        $error("debounce_scheduler: illegal N/HIST/DIV combination");
    end

    logic             tick;
    logic [N-1:0]     sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [N*HIST-1:0] hist_q, hist_d;
    logic [N-1:0]     stable_q, stable_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [HIST-1:0]  cur_hist, new_hist;
    logic             consume;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign stable   = stable_q;
    assign busy     = (state_q == SCAN);
    assign ev_valid = |pending_q;
    assign ev_level = stable_q[ev_chan];
    assign consume  = ev_valid && ev_ready;

    // Downward scan so the lowest set pending bit is the last (winning) assignment.
    always_comb begin
        ev_chan = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (pending_q[i-1]) ev_chan = CW'(i - 1);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hist_d     = hist_q;
        stable_d   = stable_q;
        pending_d  = pending_q;
        lost_event = 1'b0;
        cur_hist   = hist_q[idx_q*HIST +: HIST];
        new_hist   = {cur_hist[HIST-2:0], sync2_q[idx_q]};

        if (consume) pending_d[ev_chan] = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                hist_d[idx_q*HIST +: HIST] = new_hist;
                // A set on the channel being consumed overrides the clear above.
                if ((&new_hist && !stable_q[idx_q]) || (~|new_hist && stable_q[idx_q])) begin
                    stable_d[idx_q]  = ~stable_q[idx_q];
                    pending_d[idx_q] = 1'b1;
                    if (pending_q[idx_q] && !(consume && (ev_chan == idx_q))) lost_event = 1'b1;
                end
                if (idx_q == CW'(N - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            state_q   <= IDLE;
            idx_q     <= '0;
            hist_q    <= '1;
            stable_q  <= '1;
            pending_q <= '0;
        end else begin
            sync1_q   <= insig;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            idx_q     <= idx_d;
            hist_q    <= hist_d;
            stable_q  <= stable_d;
            pending_q <= pending_d;
        end
    end

endmodule
